fifo_pkt_reader_16: RTL and testbench

Read-side consumer of the mesochronous 512x16 packet FIFO. It dequeues one 16-word packet slot at a time: it reads the header word at offset 0 and decodes the payload length and start offset. It then reads the payload words critical-word-first and wraps within offsets 1..15. Words go out on a valid/ready stream with sop/eop markers, and the FIFO packet slot is released once the last read has been issued.

---
 rtl/fifo_pkt_reader_16.sv | 191 +++++++++++++++++++
 tb/tb_fifo_pkt_reader_16.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_reader_16.sv
// fifo_pkt_reader_16
//   Read-side consumer of the 512x16 packet FIFO. Each 16-word slot holds a
//   header at offset 0 ([15:8] tag, [7:4] len-1, [3:0] start offset) followed
//   by payload words at offsets 1..15. The payload is read critical-word-first
//   starting at the header's start offset, wrapping 15 -> 1, and streamed out
//   on a valid/ready interface with sop/eop markers. The slot is released with
//   a one-cycle o_fifo_eop pulse once the last payload read has been issued.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   o_fifo_offset     in-slot read offset (FIFO BRAM registers it; data next cycle)
//   o_fifo_eop        one-cycle slot release pulse
//   i_fifo_data       FIFO read data for the offset presented last cycle
//   i_fifo_empty      no complete packet available (sampled only when idle)
//   o_data/o_valid    payload stream, accepted on o_valid & i_ready
//   o_sop/o_eop       first / last word of the packet on the stream
//   i_ready           downstream ready
//   o_tag             header tag of the current packet
//   o_err             sticky header error (oversize length or start offset 0)
//
// Build option
//   FIFO_PKT_READER_HDR_FWD_EN: when defined, the header word itself is pushed
//   through the output buffer as the first (sop) word of each packet.
module fifo_pkt_reader_16 #(
  parameter int MAX_LEN = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  o_fifo_offset,
  output logic        o_fifo_eop,
  input  logic [15:0] i_fifo_data,
  input  logic        i_fifo_empty,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_sop,
  output logic        o_eop,
  input  logic        i_ready,
  output logic [7:0]  o_tag,
  output logic        o_err
);

`ifdef FIFO_PKT_READER_HDR_FWD_EN
  localparam logic HDR_FWD = 1'b1;
`else
  localparam logic HDR_FWD = 1'b0;
`endif

  localparam logic [4:0] MAX_LEN_W = 5'(MAX_LEN);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAY, ST_REL} state_t;
  state_t state_reg, state_next;

  logic [3:0]  rd_off_reg;
  logic [4:0]  rem_reg;
  logic        first_reg;
  logic [7:0]  tag_reg;
  logic        err_reg;

  // Read issued last cycle: its data is on i_fifo_data this cycle.
  logic        ret_valid_reg, ret_sop_reg, ret_eop_reg, ret_hdr_reg;

  // Two-entry output buffer.
  logic [15:0] buf_data_reg [2];
  logic        buf_sop_reg  [2];
  logic        buf_eop_reg  [2];
  logic        wr_ptr_reg, rd_ptr_reg;
  logic [1:0]  count_reg, count_next;

  logic [4:0]  hdr_len_raw, hdr_len;
  logic [3:0]  hdr_start;
  logic        hdr_bad;
  logic        credit_ok, pay_issue, hdr_issue;
  logic        has_buf, bypass_ok, pop, push, buf_pop;

  // Header decode, valid while in ST_HDR.
  always_comb begin
    hdr_len_raw = {1'b0, i_fifo_data[7:4]} + 5'd1;
    hdr_len     = (hdr_len_raw > MAX_LEN_W) ? MAX_LEN_W : hdr_len_raw;
    hdr_start   = (i_fifo_data[3:0] == 4'd0) ? 4'd1 : i_fifo_data[3:0];
    hdr_bad     = (hdr_len_raw > MAX_LEN_W) || (i_fifo_data[3:0] == 4'd0);
  end

  // At most two words may be buffered or in flight, so the buffer never overflows.
  assign credit_ok = (({1'b0, count_reg} + {2'b00, ret_valid_reg}) < 3'd2);

  always_comb begin
    state_next    = state_reg;
    o_fifo_offset = 4'd0;
    o_fifo_eop    = 1'b0;
    pay_issue     = 1'b0;
    hdr_issue     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!i_fifo_empty && (credit_ok || !HDR_FWD)) begin
          hdr_issue  = 1'b1;
          state_next = ST_HDR;
        end
      end
      ST_HDR: state_next = ST_PAY;
      ST_PAY: begin
        o_fifo_offset = rd_off_reg;
        if (credit_ok) begin
          pay_issue = 1'b1;
          if (rem_reg == 5'd1) state_next = ST_REL;
        end
      end
      ST_REL: begin
        // The slot pointer advances this cycle, so no read is issued here.
        o_fifo_eop = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output side: returning data bypasses an empty buffer so the first word is
  // visible in the same cycle it arrives. A forwarded header is always buffered.
  always_comb begin
    has_buf   = (count_reg != 2'd0);
    bypass_ok = ret_valid_reg && !has_buf && !ret_hdr_reg;
    o_valid   = has_buf || bypass_ok;
    o_data    = 16'h0;
    o_sop     = 1'b0;
    o_eop     = 1'b0;
    if (has_buf) begin
      o_data = buf_data_reg[rd_ptr_reg];
      o_sop  = buf_sop_reg[rd_ptr_reg];
      o_eop  = buf_eop_reg[rd_ptr_reg];
    end else if (bypass_ok) begin
      o_data = i_fifo_data;
      o_sop  = ret_sop_reg;
      o_eop  = ret_eop_reg;
    end
    pop        = o_valid && i_ready;
    push       = ret_valid_reg && !(bypass_ok && pop);
    buf_pop    = pop && has_buf;
    count_next = count_reg + {1'b0, push} - {1'b0, buf_pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      rd_off_reg    <= 4'd0;
      rem_reg       <= 5'd0;
      first_reg     <= 1'b0;
      tag_reg       <= 8'h0;
      err_reg       <= 1'b0;
      ret_valid_reg <= 1'b0;
      ret_sop_reg   <= 1'b0;
      ret_eop_reg   <= 1'b0;
      ret_hdr_reg   <= 1'b0;
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      count_reg     <= 2'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_HDR) begin
        tag_reg    <= i_fifo_data[15:8];
        rd_off_reg <= hdr_start;
        rem_reg    <= hdr_len;
        first_reg  <= 1'b1;
        if (hdr_bad) err_reg <= 1'b1;
      end
      if (pay_issue) begin
        rd_off_reg <= (rd_off_reg == 4'd15) ? 4'd1 : rd_off_reg + 4'd1;
        rem_reg    <= rem_reg - 5'd1;
        first_reg  <= 1'b0;
      end
      ret_valid_reg <= pay_issue || (hdr_issue && HDR_FWD);
      ret_hdr_reg   <= hdr_issue && HDR_FWD;
      ret_sop_reg   <= HDR_FWD ? hdr_issue : (pay_issue && first_reg);
      ret_eop_reg   <= pay_issue && (rem_reg == 5'd1);
      if (push)    wr_ptr_reg <= ~wr_ptr_reg;
      if (buf_pop) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_next;
    end
  end

  // Buffer storage needs no reset: it is only observed when count_reg != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data_reg[wr_ptr_reg] <= i_fifo_data;
      buf_sop_reg[wr_ptr_reg]  <= ret_sop_reg;
      buf_eop_reg[wr_ptr_reg]  <= ret_eop_reg;
    end
  end

  assign o_tag = tag_reg;
  assign o_err = err_reg;

endmodule

// File: tb/tb_fifo_pkt_reader_16.sv
// Testbench for fifo_pkt_reader_16 (default build, MAX_LEN = 15).
// A 4-slot FIFO model returns slot words one cycle after the offset is
// presented and advances to the next slot on o_fifo_eop.
module tb_fifo_pkt_reader_16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  o_fifo_offset;
  logic        o_fifo_eop;
  logic [15:0] i_fifo_data = 16'h0;
  logic        i_fifo_empty = 1'b1;
  logic [15:0] o_data;
  logic        o_valid, o_sop, o_eop;
  logic        i_ready = 1'b0;
  logic [7:0]  o_tag;
  logic        o_err;

  int checks = 0;
  int errors = 0;

  logic [15:0] slots [4][16];
  logic [1:0]  slot_ptr = 2'd0;

  always #5 clk = ~clk;

  fifo_pkt_reader_16 dut (
    .clk(clk), .rst(rst),
    .o_fifo_offset(o_fifo_offset), .o_fifo_eop(o_fifo_eop),
    .i_fifo_data(i_fifo_data), .i_fifo_empty(i_fifo_empty),
    .o_data(o_data), .o_valid(o_valid), .o_sop(o_sop), .o_eop(o_eop),
    .i_ready(i_ready), .o_tag(o_tag), .o_err(o_err)
  );

  // FIFO read port model: registered address, slot advances on release.
  always @(posedge clk) begin
    i_fifo_data <= slots[slot_ptr][o_fifo_offset];
    if (o_fifo_eop) slot_ptr <= slot_ptr + 2'd1;
  end

  // One line per accepted stream word.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready)
      $display("xfer t=%0t data=%h sop=%b eop=%b tag=%h", $time, o_data, o_sop, o_eop, o_tag);
  end

  task automatic cycle_end();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] p, input logic [15:0] hdr, input logic [15:0] base);
    slots[p][0] = hdr;
    for (int i = 1; i < 16; i++) slots[p][i] = base | 16'(i);
  endtask

  task automatic test_reset();
    logic [32:0] got;
    rst = 1'b1; i_fifo_empty = 1'b1; i_ready = 1'b0;
    repeat (3) cycle_end();
    @(negedge clk);
    got = {o_fifo_offset, o_fifo_eop, o_valid, o_sop, o_eop, o_data, o_tag, o_err};
    checks++;
    if (got !== 33'h0) begin
      errors++; $display("FAIL reset_values got %h exp %h", got, 33'h0);
    end
    cycle_end();
    rst = 1'b0;
    repeat (2) cycle_end();
    @(negedge clk);
    got = {o_fifo_offset, o_fifo_eop, o_valid, o_sop, o_eop, o_data, o_tag, o_err};
    checks++;
    if (got !== 33'h0) begin
      errors++; $display("FAIL idle_empty got %h exp %h", got, 33'h0);
    end
    cycle_end();
  endtask

  // Header 0x5A31: tag 5A, len 4, start 1.
  task automatic test_basic();
    logic [19:0] got, exp;
    logic        v;
    logic [1:0]  p = slot_ptr;
    load(p, 16'h5A31, 16'h0);
    for (int i = 1; i <= 4; i++) slots[p][i] = 16'(16'h1111 * i);
    i_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      i_fifo_empty = (c != 0);
      @(negedge clk);
      v   = (c >= 3 && c <= 6);
      got = {o_valid, o_fifo_eop, o_valid ? {o_sop, o_eop, o_data} : 18'h0};
      exp = {v, c == 6, v ? {c == 3, c == 6, 16'(16'h1111 * (c - 2))} : 18'h0};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL basic_stream c%0d got %h exp %h", c, got, exp);
      end
      if (c == 0 || (c >= 2 && c <= 5)) begin
        checks++;
        if (o_fifo_offset !== 4'((c == 0) ? 0 : c - 1)) begin
          errors++; $display("FAIL basic_offset c%0d got %0d exp %0d", c, o_fifo_offset, (c == 0) ? 0 : c - 1);
        end
      end
      if (c >= 2) begin
        checks++;
        if ({o_tag, o_err} !== {8'h5A, 1'b0}) begin
          errors++; $display("FAIL basic_tag c%0d got %h/%b exp 5a/0", c, o_tag, o_err);
        end
      end
      cycle_end();
    end
  endtask

  // len 3, start 14: read order 14, 15, 1.
  task automatic test_wrap();
    logic [19:0] got, exp;
    logic        v;
    int          ord [3];
    logic [1:0]  p = slot_ptr;
    ord = '{14, 15, 1};
    load(p, 16'h3C2E, 16'hA000);
    i_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      i_fifo_empty = (c != 0);
      @(negedge clk);
      v   = (c >= 3 && c <= 5);
      got = {o_valid, o_fifo_eop, o_valid ? {o_sop, o_eop, o_data} : 18'h0};
      exp = {v, c == 5, v ? {c == 3, c == 5, 16'h0} : 18'h0};
      if (v) exp[15:0] = 16'hA000 | 16'(ord[c - 3]);
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL wrap_stream c%0d got %h exp %h", c, got, exp);
      end
      if (c >= 2 && c <= 4) begin
        checks++;
        if (o_fifo_offset !== 4'(ord[c - 2])) begin
          errors++; $display("FAIL wrap_offset c%0d got %0d exp %0d", c, o_fifo_offset, ord[c - 2]);
        end
      end
      cycle_end();
    end
  endtask

  // len 15, start 1, ready toggling every cycle.
  task automatic test_backpressure();
    int          got_n = 0;
    int          feop_n = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = 16'h0;
    logic [17:0] got, exp;
    load(slot_ptr, 16'h77E1, 16'hB000);
    for (int c = 0; c < 50; c++) begin
      i_fifo_empty = (c != 0);
      i_ready      = (c % 2 == 0);
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (!o_valid || o_data !== prev_data) begin
          errors++; $display("FAIL bp_hold c%0d got %b/%h exp 1/%h", c, o_valid, o_data, prev_data);
        end
      end
      if (o_valid && i_ready) begin
        got = {o_sop, o_eop, o_data};
        exp = {got_n == 0, got_n == 14, 16'hB000 | 16'(got_n + 1)};
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL bp_word n%0d got %h exp %h", got_n, got, exp);
        end
        got_n++;
      end
      if (o_fifo_eop) feop_n++;
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
      cycle_end();
    end
    checks++;
    if (got_n != 15 || feop_n != 1) begin
      errors++; $display("FAIL bp_counts got %0d words %0d rel exp 15 words 1 rel", got_n, feop_n);
    end
    i_ready = 1'b1;
  endtask

  // Header 0x00F0: len 16 clamped to 15, start 0 forced to 1, error flagged.
  task automatic test_clamp();
    logic [19:0] got, exp;
    logic        v;
    load(slot_ptr, 16'h00F0, 16'hC000);
    i_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      i_fifo_empty = (c != 0);
      @(negedge clk);
      v   = (c >= 3 && c <= 17);
      got = {o_valid, o_fifo_eop, o_valid ? {o_sop, o_eop, o_data} : 18'h0};
      exp = {v, c == 17, v ? {c == 3, c == 17, 16'hC000 | 16'(c - 2)} : 18'h0};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL clamp_stream c%0d got %h exp %h", c, got, exp);
      end
      if (c == 2 || c == 19) begin
        checks++;
        if (o_err !== 1'b1) begin
          errors++; $display("FAIL clamp_err c%0d got %b exp 1", c, o_err);
        end
      end
      cycle_end();
    end
  endtask

  // Two packets queued: second header read in the cycle after the first release.
  task automatic test_back_to_back();
    logic [19:0] got, exp;
    logic        v;
    logic [1:0]  p = slot_ptr;
    logic [1:0]  q = slot_ptr + 2'd1;
    load(p, 16'h1122, 16'hD000);
    load(q, 16'h2211, 16'hE000);
    i_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      i_fifo_empty = (c >= 7);
      @(negedge clk);
      v   = (c >= 3 && c <= 5) || (c >= 9 && c <= 10);
      got = {o_valid, o_fifo_eop, o_valid ? {o_sop, o_eop, o_data} : 18'h0};
      exp = {v, c == 5 || c == 10, 18'h0};
      if (c >= 3 && c <= 5) exp[17:0] = {c == 3, c == 5, 16'hD000 | 16'(c - 1)};
      if (c >= 9 && c <= 10) exp[17:0] = {c == 9, c == 10, 16'hE000 | 16'(c - 8)};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL b2b_stream c%0d got %h exp %h", c, got, exp);
      end
      if (c == 6 || c == 8) begin
        checks++;
        if (o_fifo_offset !== ((c == 6) ? 4'd0 : 4'd1)) begin
          errors++; $display("FAIL b2b_offset c%0d got %0d exp %0d", c, o_fifo_offset, (c == 6) ? 0 : 1);
        end
      end
      if (c == 3 || c == 9) begin
        checks++;
        if ({o_tag, o_err} !== {(c == 3) ? 8'h11 : 8'h22, 1'b1}) begin
          errors++; $display("FAIL b2b_tag_err c%0d got %h/%b exp %h/1", c, o_tag, o_err, (c == 3) ? 8'h11 : 8'h22);
        end
      end
      cycle_end();
    end
  endtask

  // Reset after two payload reads; the same slot replays from its header.
  task automatic test_reset_mid();
    logic [19:0] got, exp;
    logic [32:0] all;
    logic        v;
    load(slot_ptr, 16'h4451, 16'hF000);
    i_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      i_fifo_empty = (c >= 6);
      rst          = (c == 4);
      @(negedge clk);
      v   = (c >= 3 && c <= 4) || (c >= 8 && c <= 13);
      got = {o_valid, o_fifo_eop, o_valid ? {o_sop, o_eop, o_data} : 18'h0};
      exp = {v, c == 13, v ? {c == 3 || c == 8, c == 13, 16'hF000 | 16'((c < 5) ? c - 2 : c - 7)} : 18'h0};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL rstmid_stream c%0d got %h exp %h", c, got, exp);
      end
      if (c == 5) begin
        all = {o_fifo_offset, o_fifo_eop, o_valid, o_sop, o_eop, o_data, o_tag, o_err};
        checks++;
        if (all !== 33'h0) begin
          errors++; $display("FAIL rstmid_values got %h exp %h", all, 33'h0);
        end
      end
      if (c == 10) begin
        checks++;
        if ({o_tag, o_err} !== {8'h44, 1'b0}) begin
          errors++; $display("FAIL rstmid_tag got %h/%b exp 44/0", o_tag, o_err);
        end
      end
      cycle_end();
    end
  endtask

  initial begin
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 16; i++) slots[s][i] = 16'h0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
